// File: rtl/jpu_uart_loader.sv
// UART boot loader: frames a program image into instruction memory and holds the core in reset until a good frame lands.
// Define JPU_LOADER_CKSUM_EN to require and check a trailing XOR checksum byte after the data words.
module jpu_uart_loader #(
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         CNT_W          = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              loading,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef JPU_LOADER_CKSUM_EN
    CKSUM,
`endif
    RUN,
    ERROR
  } state_t;

`ifdef JPU_LOADER_CKSUM_EN
  localparam state_t AFTER_DATA = CKSUM;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS   = 17'(1) << ADDR_W;
  localparam logic [1:0]       ERR_NONE    = 2'd0;
  localparam logic [1:0]       ERR_COUNT   = 2'd1;
  localparam logic [1:0]       ERR_CKSUM   = 2'd2;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd3;

  state_t             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        word_q, word_d;
  logic [1:0]         byte_q, byte_d;
  logic [31:0]        asm_q, asm_d;
  logic [7:0]         ck_q, ck_d;
  logic [CNT_W-1:0]   to_q, to_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic               active;
  logic               is_sync;
  logic [15:0]        n_word;
  logic [31:0]        asm_word;

  assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
  assign n_word   = {rx_data, cnt_lo_q};
  // Bytes enter from the top so byte0 ends up in bits 7:0 after four shifts.
  assign asm_word = {rx_data, asm_q[31:8]};

  always_comb begin
    active = 1'b0;
    case (state_q)
      CNT_LO, CNT_HI, DATA: active = 1'b1;
`ifdef JPU_LOADER_CKSUM_EN
      CKSUM:                active = 1'b1;
`endif
      default:              active = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_d     = word_q;
    byte_d     = byte_q;
    asm_d      = asm_q;
    ck_d       = ck_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    code_d     = code_q;
    to_d       = '0;
    core_rst_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (is_sync) state_d = CNT_LO;
      end
      CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          count_d = n_word;
          word_d  = '0;
          byte_d  = '0;
          ck_d    = '0;
          if ({1'b0, n_word} > MAX_WORDS) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_COUNT;
          end else if (n_word == 16'd0) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_d  = asm_word;
          ck_d   = ck_q ^ rx_data;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_q[ADDR_W-1:0];
            wdata_d = asm_word;
            word_d  = word_q + 16'd1;
            if (word_q == count_q - 16'd1) state_d = AFTER_DATA;
          end
        end
      end
`ifdef JPU_LOADER_CKSUM_EN
      CKSUM: begin
        if (rx_valid) begin
          if (rx_data == ck_q) begin
            state_d = RUN;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_CKSUM;
          end
        end
      end
`endif
      RUN: begin
        // Non-sync bytes belong to the running program.
        if (is_sync) state_d = CNT_LO;
      end
      ERROR: begin
        if (is_sync) begin
          state_d = CNT_LO;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte landing on the expiry cycle wins, so only idle cycles can time out.
    if (active) begin
      if (rx_valid) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        state_d = ERROR;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    core_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      asm_q      <= '0;
      ck_q       <= '0;
      to_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      asm_q      <= asm_d;
      ck_q       <= ck_d;
      to_q       <= to_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign loading   = active;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
